// File: rtl/ov7670_config_sequencer_if.sv
// SCCB write-request handshake between the config sequencer and the SCCB master.
interface ov7670_config_sequencer_if;
   logic       valid;
   logic       ready;
   logic [7:0] id;
   logic [7:0] addr;
   logic [7:0] data;

   modport master (output valid, id, addr, data, input ready);
   modport slave  (input valid, id, addr, data, output ready);
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and turns each entry into an SCCB register write.
module ov7670_config_sequencer #(
   parameter int unsigned DELAY_CYCLES = 1_000_000,
   parameter logic [7:0]  SCCB_ID      = 8'h42
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start_i,
   output logic [7:0]                       rom_addr_o,
   output logic                             rom_clk_en_o,
   input  logic [15:0]                      rom_dout_i,
   ov7670_config_sequencer_if.master        sccb,
   output logic                             busy_o,
   output logic                             done_o
);

   localparam int unsigned CW =
      (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [CW-1:0] DLY_LOAD = CW'(DELAY_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, SEND, DELAY, DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [7:0]    addr_q;
   logic          en_q;
   logic          valid_q;
   logic          busy_q;
   logic          done_q;
   logic [7:0]    reg_q;
   logic [7:0]    data_q;
   logic          last_w;

   // Entry 255 is the last one; the table never wraps back to 0.
   assign last_w = (addr_q == 8'hFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         reg_q   <= '0;
         data_q  <= '0;
      end else begin
         en_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  done_q  <= 1'b0;
                  addr_q  <= '0;
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: state_q <= DECODE;
            DECODE: begin
               unique case (1'b1)
                  (rom_dout_i == 16'hFFFF): begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
                  (rom_dout_i == 16'hFFF0): begin
                     cnt_q   <= DLY_LOAD;
                     state_q <= DELAY;
                  end
                  default: begin
                     reg_q   <= rom_dout_i[15:8];
                     data_q  <= rom_dout_i[7:0];
                     valid_q <= 1'b1;
                     state_q <= SEND;
                  end
               endcase
            end
            SEND: begin
               if (sccb.ready) begin
                  valid_q <= 1'b0;
                  if (last_w) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     addr_q  <= addr_q + 8'd1;
                     en_q    <= 1'b1;
                     state_q <= FETCH;
                  end
               end
            end
            DELAY: begin
               if (cnt_q == '0) begin
                  if (last_w) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     addr_q  <= addr_q + 8'd1;
                     en_q    <= 1'b1;
                     state_q <= FETCH;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr_o   = addr_q;
   assign rom_clk_en_o = en_q;
   assign sccb.valid   = valid_q;
   assign sccb.id      = SCCB_ID;
   assign sccb.addr    = reg_q;
   assign sccb.data    = data_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for the OV7670 config sequencer: ROM model, SCCB monitor, table-walk reference.
module tb_ov7670_config_sequencer;
   localparam int DLY = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic        rom_clk_en;
   logic [15:0] rom_dout = '0;
   logic        busy;
   logic        done;

   ov7670_config_sequencer_if sccb ();

   ov7670_config_sequencer #(
      .DELAY_CYCLES (DLY),
      .SCCB_ID      (8'h42)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .rom_addr_o   (rom_addr),
      .rom_clk_en_o (rom_clk_en),
      .rom_dout_i   (rom_dout),
      .sccb         (sccb),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [256];

   always @(posedge clk)
      if (rom_clk_en) rom_dout <= rom[rom_addr];

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  r;
      logic [7:0]  d;
      int unsigned c;
   } xfer_t;

   xfer_t       mon_q[$];
   int unsigned cyc = 0;
   int          viol = 0;
   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic [7:0]  pa = '0;
   logic [7:0]  pd = '0;

   // Transfers happen on the posedge following a negedge where valid&ready.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (pv && !pr &&
             (!sccb.valid || sccb.addr !== pa || sccb.data !== pd))
            viol <= viol + 1;
         if (sccb.valid && sccb.ready)
            mon_q.push_back('{a: rom_addr, r: sccb.addr,
                              d: sccb.data, c: cyc});
      end
      pv <= sccb.valid && rst_n;
      pr <= sccb.ready;
      pa <= sccb.addr;
      pd <= sccb.data;
   end

   typedef struct {
      logic [15:0] rd;
      logic [7:0]  idx;
      int          t;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] exp_last;
   int         checks = 0;
   int         fails = 0;

   // Each entry costs fetch+decode; writes add one send cycle, delays DLY.
   task automatic build_model();
      int t = 0;
      exp_q.delete();
      exp_last = 8'hFF;
      for (int a = 0; a < 256; a++) begin
         t += 2;
         if (rom[a] == 16'hFFFF) begin
            exp_last = 8'(a);
            break;
         end else if (rom[a] == 16'hFFF0) begin
            t += DLY;
         end else begin
            exp_q.push_back('{rom[a], 8'(a), t});
            t += 1;
         end
      end
   endtask

   task automatic load_std();
      for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
      rom[0] = 16'h1280;
      rom[1] = 16'hFFF0;
      rom[2] = 16'h1201;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd,
                            output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (rnd) sccb.ready = 1'($urandom_range(0, 1));
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (sccb.valid) break;
      end
   endtask

   task automatic test_reset();
      sccb.ready = 1'b1;
      #23;
      checks += 8;
      if (rom_addr !== 8'h00) begin fails++; $display("FAIL rst_rom_addr got %h want 00", rom_addr); end
      if (rom_clk_en !== 1'b0) begin fails++; $display("FAIL rst_rom_clk_en got %b want 0", rom_clk_en); end
      if (sccb.valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", sccb.valid); end
      if (sccb.addr !== 8'h00) begin fails++; $display("FAIL rst_reg got %h want 00", sccb.addr); end
      if (sccb.data !== 8'h00) begin fails++; $display("FAIL rst_data got %h want 00", sccb.data); end
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
      if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
      if (sccb.id !== 8'h42) begin fails++; $display("FAIL rst_id got %h want 42", sccb.id); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks += 2;
      if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", busy); end
      if (rom_clk_en !== 1'b0) begin fails++; $display("FAIL idle_en got %b want 0", rom_clk_en); end
   endtask

   task automatic test_basic();
      int n;
      bit ok;
      load_std();
      build_model();
      mon_q.delete();
      pulse_start();
      wait_valid(n);
      checks++;
      if (n !== 3) begin fails++; $display("FAIL basic_latency got %0d want 3", n); end
      wait_done(300, 1'b0, ok);
      checks += 5;
      if (!ok) begin fails++; $display("FAIL basic_timeout got 0 want 1"); end
      if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy got %b want 0", busy); end
      if (rom_addr !== exp_last) begin fails++; $display("FAIL basic_addr got %h want %h", rom_addr, exp_last); end
      if (mon_q.size() !== exp_q.size()) begin fails++; $display("FAIL basic_count got %0d want %0d", mon_q.size(), exp_q.size()); end
      if (mon_q.size() == 2 && (mon_q[1].c - mon_q[0].c) !== 32'(exp_q[1].t - exp_q[0].t)) begin
         fails++; $display("FAIL basic_gap got %0d want %0d", mon_q[1].c - mon_q[0].c, exp_q[1].t - exp_q[0].t);
      end
      foreach (exp_q[i]) if (i < mon_q.size()) begin
         checks++;
         if ({mon_q[i].r, mon_q[i].d} !== exp_q[i].rd || mon_q[i].a !== exp_q[i].idx) begin
            fails++; $display("FAIL basic_wr%0d got %h%h@%h want %h@%h", i, mon_q[i].r, mon_q[i].d, mon_q[i].a, exp_q[i].rd, exp_q[i].idx);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      int v0;
      bit ok;
      load_std();
      build_model();
      mon_q.delete();
      v0 = viol;
      @(posedge clk); #1 sccb.ready = 1'b0;
      pulse_start();
      wait_valid(n);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if ({sccb.valid, sccb.addr, sccb.data, rom_addr} !== {1'b1, 24'h128000}) begin
            fails++; $display("FAIL bp_hold%0d got %b %h %h %h want 1 12 80 00", k, sccb.valid, sccb.addr, sccb.data, rom_addr);
         end
      end
      @(posedge clk); #1 sccb.ready = 1'b1;
      wait_done(300, 1'b0, ok);
      checks += 3;
      if (!ok) begin fails++; $display("FAIL bp_timeout got 0 want 1"); end
      if (viol - v0 !== 0) begin fails++; $display("FAIL bp_stable got %0d want 0", viol - v0); end
      if (mon_q.size() !== exp_q.size()) begin fails++; $display("FAIL bp_count got %0d want %0d", mon_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < mon_q.size()) begin
         checks++;
         if ({mon_q[i].r, mon_q[i].d} !== exp_q[i].rd || mon_q[i].a !== exp_q[i].idx) begin
            fails++; $display("FAIL bp_wr%0d got %h%h want %h", i, mon_q[i].r, mon_q[i].d, exp_q[i].rd);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int n;
      bit ok;
      load_std();
      build_model();
      mon_q.delete();
      @(posedge clk); #1 sccb.ready = 1'b0;
      pulse_start();
      wait_valid(n);
      pulse_start();
      @(posedge clk); #1 sccb.ready = 1'b1;
      for (int i = 0; i < 20 && mon_q.size() == 0; i++) @(posedge clk);
      repeat (6) @(posedge clk);
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin fails++; $display("FAIL swb_busy got %b want 1", busy); end
      wait_done(300, 1'b0, ok);
      checks += 3;
      if (!ok) begin fails++; $display("FAIL swb_timeout got 0 want 1"); end
      if (mon_q.size() !== exp_q.size()) begin fails++; $display("FAIL swb_count got %0d want %0d", mon_q.size(), exp_q.size()); end
      if (mon_q.size() == 2 && (mon_q[1].c - mon_q[0].c) !== 32'(exp_q[1].t - exp_q[0].t)) begin
         fails++; $display("FAIL swb_gap got %0d want %0d", mon_q[1].c - mon_q[0].c, exp_q[1].t - exp_q[0].t);
      end
      foreach (exp_q[i]) if (i < mon_q.size()) begin
         checks++;
         if ({mon_q[i].r, mon_q[i].d} !== exp_q[i].rd || mon_q[i].a !== exp_q[i].idx) begin
            fails++; $display("FAIL swb_wr%0d got %h%h want %h", i, mon_q[i].r, mon_q[i].d, exp_q[i].rd);
         end
      end
   endtask

   task automatic test_reset_mid_delay();
      bit ok;
      load_std();
      build_model();
      mon_q.delete();
      sccb.ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 20 && mon_q.size() == 0; i++) @(posedge clk);
      repeat (8) @(posedge clk);
      #3;
      checks++;
      if (busy !== 1'b1) begin fails++; $display("FAIL rmd_pre_busy got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rom_addr, rom_clk_en, sccb.valid, sccb.addr, sccb.data, busy, done} !== 28'h0) begin
         fails++; $display("FAIL rmd_outputs got %h %b %b %h %h %b %b want all 0", rom_addr, rom_clk_en, sccb.valid, sccb.addr, sccb.data, busy, done);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin fails++; $display("FAIL rmd_idle got %b want 0", busy); end
      mon_q.delete();
      pulse_start();
      wait_done(300, 1'b0, ok);
      checks += 2;
      if (!ok) begin fails++; $display("FAIL rmd_timeout got 0 want 1"); end
      if (mon_q.size() !== exp_q.size()) begin fails++; $display("FAIL rmd_count got %0d want %0d", mon_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < mon_q.size()) begin
         checks++;
         if ({mon_q[i].r, mon_q[i].d} !== exp_q[i].rd || mon_q[i].a !== exp_q[i].idx) begin
            fails++; $display("FAIL rmd_wr%0d got %h%h want %h", i, mon_q[i].r, mon_q[i].d, exp_q[i].rd);
         end
      end
   endtask

   task automatic test_restart_after_done();
      bit ok;
      load_std();
      build_model();
      checks++;
      if (done !== 1'b1) begin fails++; $display("FAIL rad_pre_done got %b want 1", done); end
      mon_q.delete();
      pulse_start();
      checks += 2;
      if (done !== 1'b0) begin fails++; $display("FAIL rad_done_clr got %b want 0", done); end
      if (busy !== 1'b1) begin fails++; $display("FAIL rad_busy got %b want 1", busy); end
      wait_done(300, 1'b0, ok);
      checks += 2;
      if (!ok) begin fails++; $display("FAIL rad_timeout got 0 want 1"); end
      if (mon_q.size() !== exp_q.size()) begin fails++; $display("FAIL rad_count got %0d want %0d", mon_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < mon_q.size()) begin
         checks++;
         if ({mon_q[i].r, mon_q[i].d} !== exp_q[i].rd || mon_q[i].a !== exp_q[i].idx) begin
            fails++; $display("FAIL rad_wr%0d got %h%h want %h", i, mon_q[i].r, mon_q[i].d, exp_q[i].rd);
         end
      end
   endtask

   task automatic test_full_table();
      bit ok;
      for (int a = 0; a < 256; a++) rom[a] = 16'h0A55;
      build_model();
      mon_q.delete();
      sccb.ready = 1'b1;
      pulse_start();
      wait_done(1500, 1'b0, ok);
      repeat (5) @(negedge clk);
      checks += 5;
      if (!ok) begin fails++; $display("FAIL full_timeout got 0 want 1"); end
      if (mon_q.size() !== 256) begin fails++; $display("FAIL full_count got %0d want 256", mon_q.size()); end
      if (done !== 1'b1) begin fails++; $display("FAIL full_done got %b want 1", done); end
      if (rom_addr !== 8'hFF) begin fails++; $display("FAIL full_addr got %h want ff", rom_addr); end
      if (busy !== 1'b0) begin fails++; $display("FAIL full_busy got %b want 0", busy); end
      foreach (exp_q[i]) if (i < mon_q.size()) begin
         checks++;
         if ({mon_q[i].r, mon_q[i].d} !== exp_q[i].rd || mon_q[i].a !== exp_q[i].idx) begin
            fails++; $display("FAIL full_wr%0d got %h%h@%h want %h@%h", i, mon_q[i].r, mon_q[i].d, mon_q[i].a, exp_q[i].rd, exp_q[i].idx);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int v0;
      for (int it = 0; it < 4; it++) begin
         for (int a = 0; a < 256; a++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 3) rom[a] = 16'hFFF0;
            else if (r < 5) rom[a] = 16'hFFFF;
            else rom[a] = 16'($urandom);
         end
         build_model();
         mon_q.delete();
         v0 = viol;
         pulse_start();
         wait_done(5000, 1'b1, ok);
         checks += 5;
         if (!ok) begin fails++; $display("FAIL rnd%0d_timeout got 0 want 1", it); end
         if (viol - v0 !== 0) begin fails++; $display("FAIL rnd%0d_stable got %0d want 0", it, viol - v0); end
         if (rom_addr !== exp_last) begin fails++; $display("FAIL rnd%0d_addr got %h want %h", it, rom_addr, exp_last); end
         if (busy !== 1'b0) begin fails++; $display("FAIL rnd%0d_busy got %b want 0", it, busy); end
         if (mon_q.size() !== exp_q.size()) begin fails++; $display("FAIL rnd%0d_count got %0d want %0d", it, mon_q.size(), exp_q.size()); end
         foreach (exp_q[i]) if (i < mon_q.size()) begin
            checks++;
            if ({mon_q[i].r, mon_q[i].d} !== exp_q[i].rd || mon_q[i].a !== exp_q[i].idx) begin
               fails++; $display("FAIL rnd%0d_wr%0d got %h%h@%h want %h@%h", it, i, mon_q[i].r, mon_q[i].d, mon_q[i].a, exp_q[i].rd, exp_q[i].idx);
            end
         end
      end
      sccb.ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_delay();
      test_restart_after_done();
      test_full_table();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
